// File: rtl/mod_icache_assoc.sv
// N-way set-associative L1 instruction cache with tree pseudo-LRU replacement and multi-beat fill.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module mod_icache_assoc #(
   parameter int WORDSIZE = 64,
   parameter int LOGWIDTH = 6,
   parameter int LOGDEPTH = 9,
   parameter int LOGWAYS  = 2,
   parameter int ADDRSIZE = 64,
   parameter int TAGWIDTH = 13,
   parameter int HIT_LAT  = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [ADDRSIZE-1:0]            core_req,
   input  logic [TAGWIDTH-1:0]            core_reqtag,
   input  logic                           core_reqcyc,
   output logic                           core_reqack,
   output logic [(1<<LOGWIDTH)*8-1:0]     core_resp,
   output logic [TAGWIDTH-1:0]            core_resptag,
   output logic                           core_respcyc,
   input  logic                           core_respack,
   output logic [ADDRSIZE-1:0]            mem_req,
   output logic [TAGWIDTH-1:0]            mem_reqtag,
   output logic                           mem_reqcyc,
   input  logic                           mem_reqack,
   input  logic [WORDSIZE-1:0]            mem_resp,
   input  logic [TAGWIDTH-1:0]            mem_resptag,
   input  logic                           mem_respcyc,
   output logic                           mem_respack,
   output logic [31:0]                    hit_count,
   output logic [31:0]                    miss_count
);

   localparam int BLKBITS = (1 << LOGWIDTH) * 8;
   localparam int BEATS   = BLKBITS / WORDSIZE;
   localparam int BEATW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WAYS    = 1 << LOGWAYS;
   localparam int WAYW    = (LOGWAYS > 0) ? LOGWAYS : 1;
   localparam int SETBITS = LOGDEPTH - LOGWAYS;
   localparam int SETS    = 1 << SETBITS;
   localparam int DEPTH   = 1 << LOGDEPTH;
   localparam int ATAGW   = ADDRSIZE - LOGWIDTH - SETBITS;
   localparam int LATW    = $clog2(HIT_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_HIT_RD, S_MISS_REQ, S_MISS_WAIT, S_RESP
   } state_t;

   state_t               state_q, state_d;
   logic [ADDRSIZE-1:0]  addr_q, addr_d;
   logic [TAGWIDTH-1:0]  tag_q, tag_d;
   logic [WAYW-1:0]      way_q, way_d;
   logic [LATW-1:0]      lat_q, lat_d;
   logic [BEATW-1:0]     beat_q, beat_d;
   logic [BLKBITS-1:0]   fill_q, fill_d;
   logic                 reqack_q, reqack_d;
   logic                 respcyc_q, respcyc_d;
   logic [BLKBITS-1:0]   resp_q, resp_d;
   logic [TAGWIDTH-1:0]  resptag_q, resptag_d;
   logic                 mem_reqcyc_q, mem_reqcyc_d;
   logic [ADDRSIZE-1:0]  mem_req_q, mem_req_d;
   logic [TAGWIDTH-1:0]  mem_reqtag_q, mem_reqtag_d;

   logic [WAYS-1:0]      valid_q [SETS];
   logic [WAYS-1:0]      plru_q  [SETS];
   logic [ATAGW-1:0]     atag_q  [DEPTH];
   logic [BLKBITS-1:0]   blk_ram [DEPTH];
   logic [BLKBITS-1:0]   rd_data_q;

   logic [SETBITS-1:0]   set_idx;
   logic [ATAGW-1:0]     atag;
   logic [WAYS-1:0]      hit_vec;
   logic [WAYW-1:0]      hit_way;
   logic [WAYW-1:0]      victim;
   logic                 lookup_hit, lookup_miss, fill_done;
   logic                 plru_we;
   logic [WAYW-1:0]      plru_way;
   logic                 unused_offset;

   // PLRU node bits form a heap rooted at index 1; a bit points toward the victim side.
   function automatic logic [WAYW-1:0] plru_victim(input logic [WAYS-1:0] bits);
      int node;
      node = 1;
      for (int l = 0; l < LOGWAYS; l++) node = 2 * node + int'(bits[node]);
      return WAYW'(node - WAYS);
   endfunction

   function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits,
                                                  input logic [WAYW-1:0] way);
      logic [WAYS-1:0] r;
      int node;
      int dir;
      r    = bits;
      node = 1;
      for (int l = 0; l < LOGWAYS; l++) begin
         dir     = (int'(way) >> (LOGWAYS - 1 - l)) & 1;
         r[node] = (dir == 0);
         node    = 2 * node + dir;
      end
      return r;
   endfunction

   function automatic logic [LOGDEPTH-1:0] ram_addr(input logic [WAYW-1:0] way,
                                                    input logic [SETBITS-1:0] set);
      return LOGDEPTH'(int'(way) * SETS + int'(set));
   endfunction

   assign set_idx       = addr_q[LOGWIDTH +: SETBITS];
   assign atag          = addr_q[ADDRSIZE-1 -: ATAGW];
   assign unused_offset = ^addr_q[LOGWIDTH-1:0];

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      victim  = plru_victim(plru_q[set_idx]);
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_vec[w] = valid_q[set_idx][w] &&
                      (atag_q[ram_addr(WAYW'(w), set_idx)] == atag);
         if (hit_vec[w]) hit_way = WAYW'(w);
         if (!valid_q[set_idx][w]) victim = WAYW'(w);
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      tag_d        = tag_q;
      way_d        = way_q;
      lat_d        = lat_q;
      beat_d       = beat_q;
      fill_d       = fill_q;
      reqack_d     = 1'b0;
      respcyc_d    = respcyc_q;
      resp_d       = resp_q;
      resptag_d    = resptag_q;
      mem_reqcyc_d = mem_reqcyc_q;
      mem_req_d    = mem_req_q;
      mem_reqtag_d = mem_reqtag_q;
      lookup_hit   = 1'b0;
      lookup_miss  = 1'b0;
      fill_done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (core_reqcyc) begin
               addr_d   = core_req;
               tag_d    = core_reqtag;
               reqack_d = 1'b1;
               state_d  = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (|hit_vec) begin
               lookup_hit = 1'b1;
               way_d      = hit_way;
               lat_d      = '0;
               state_d    = S_HIT_RD;
            end else begin
               lookup_miss  = 1'b1;
               way_d        = victim;
               mem_reqcyc_d = 1'b1;
               mem_req_d    = {addr_q[ADDRSIZE-1:LOGWIDTH], {LOGWIDTH{1'b0}}};
               mem_reqtag_d = tag_q;
               state_d      = S_MISS_REQ;
            end
         end
         S_HIT_RD: begin
            if (lat_q == LATW'(HIT_LAT - 1)) begin
               resp_d    = rd_data_q;
               resptag_d = tag_q;
               respcyc_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_MISS_REQ: begin
            if (mem_reqack) begin
               mem_reqcyc_d = 1'b0;
               beat_d       = '0;
               state_d      = S_MISS_WAIT;
            end
         end
         S_MISS_WAIT: begin
            // Beats carrying a foreign tag are acked by mem_respack but never stored.
            if (mem_respcyc && (mem_resptag == tag_q)) begin
               fill_d[beat_q*WORDSIZE +: WORDSIZE] = mem_resp;
               if (beat_q == BEATW'(BEATS - 1)) begin
                  fill_done = 1'b1;
                  beat_d    = '0;
                  resp_d    = fill_d;
                  resptag_d = tag_q;
                  respcyc_d = 1'b1;
                  state_d   = S_RESP;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_RESP: begin
            if (core_respack) begin
               respcyc_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign plru_we  = lookup_hit | fill_done;
   assign plru_way = (state_q == S_LOOKUP) ? hit_way : way_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         way_q        <= '0;
         lat_q        <= '0;
         beat_q       <= '0;
         reqack_q     <= 1'b0;
         respcyc_q    <= 1'b0;
         resp_q       <= '0;
         resptag_q    <= '0;
         mem_reqcyc_q <= 1'b0;
         mem_req_q    <= '0;
         mem_reqtag_q <= '0;
      end else begin
         state_q      <= state_d;
         way_q        <= way_d;
         lat_q        <= lat_d;
         beat_q       <= beat_d;
         reqack_q     <= reqack_d;
         respcyc_q    <= respcyc_d;
         resp_q       <= resp_d;
         resptag_q    <= resptag_d;
         mem_reqcyc_q <= mem_reqcyc_d;
         mem_req_q    <= mem_req_d;
         mem_reqtag_q <= mem_reqtag_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         if (plru_we) plru_q[set_idx] <= plru_touch(plru_q[set_idx], plru_way);
         if (fill_done) valid_q[set_idx][way_q] <= 1'b1;
      end
   end

   // Datapath storage: request latch, fill buffer, tag array and block SRAM carry no reset.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      tag_q  <= tag_d;
      fill_q <= fill_d;
      if (fill_done) begin
         atag_q[ram_addr(way_q, set_idx)]  <= atag;
         blk_ram[ram_addr(way_q, set_idx)] <= fill_d;
      end
      if (lookup_hit) rd_data_q <= blk_ram[ram_addr(hit_way, set_idx)];
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q + {31'd0, lookup_hit};
      miss_count_d = miss_count_q + {31'd0, lookup_miss};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

   assign core_reqack  = reqack_q;
   assign core_respcyc = respcyc_q;
   assign core_resp    = resp_q;
   assign core_resptag = resptag_q;
   assign mem_reqcyc   = mem_reqcyc_q;
   assign mem_req      = mem_req_q;
   assign mem_reqtag   = mem_reqtag_q;
   assign mem_respack  = mem_respcyc;

endmodule

// File: tb/tb_mod_icache_assoc.sv
// Randomized bench for mod_icache_assoc against a recency-based cache model.
module tb_mod_icache_assoc;
   localparam int HIT_LAT = 1;
   localparam int SETS    = 128;
   localparam int WAYS    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [63:0]   core_req;
   logic [12:0]   core_reqtag;
   logic          core_reqcyc;
   logic          core_reqack;
   logic [511:0]  core_resp;
   logic [12:0]   core_resptag;
   logic          core_respcyc;
   logic          core_respack;
   logic [63:0]   mem_req;
   logic [12:0]   mem_reqtag;
   logic          mem_reqcyc;
   logic          mem_reqack;
   logic [63:0]   mem_resp;
   logic [12:0]   mem_resptag;
   logic          mem_respcyc;
   logic          mem_respack;
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;

   always #5 clk = ~clk;

   mod_icache_assoc #(
      .WORDSIZE(64), .LOGWIDTH(6), .LOGDEPTH(9), .LOGWAYS(2),
      .ADDRSIZE(64), .TAGWIDTH(13), .HIT_LAT(HIT_LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_reqtag(core_reqtag), .core_reqcyc(core_reqcyc),
      .core_reqack(core_reqack), .core_resp(core_resp), .core_resptag(core_resptag),
      .core_respcyc(core_respcyc), .core_respack(core_respack),
      .mem_req(mem_req), .mem_reqtag(mem_reqtag), .mem_reqcyc(mem_reqcyc),
      .mem_reqack(mem_reqack), .mem_resp(mem_resp), .mem_resptag(mem_resptag),
      .mem_respcyc(mem_respcyc), .mem_respack(mem_respack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string name, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Model: per set, which half was touched last and which way inside each half.
   logic          m_valid [SETS][WAYS];
   logic [50:0]   m_tag   [SETS][WAYS];
   logic [511:0]  m_data  [SETS][WAYS];
   int            m_last_half [SETS];
   int            m_last_in   [SETS][2];
   int            m_hits;
   int            m_misses;

   function automatic void model_clear();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
         m_last_half[s] = 1;
         m_last_in[s][0] = 1;
         m_last_in[s][1] = 1;
      end
      m_hits = 0;
      m_misses = 0;
   endfunction

   function automatic void model_touch(input int s, input int w);
      m_last_half[s]        = w / 2;
      m_last_in[s][w / 2]   = w % 2;
   endfunction

   function automatic int model_victim(input int s);
      int h;
      for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
      h = 1 - m_last_half[s];
      return 2 * h + (1 - m_last_in[s][h]);
   endfunction

   task automatic check_counters();
`ifdef ICACHE_PERF_EN
      check_eq("hit_count", hit_count, m_hits);
      check_eq("miss_count", miss_count, m_misses);
`else
      check_eq("hit_count", hit_count, 0);
      check_eq("miss_count", miss_count, 0);
`endif
   endtask

   task automatic check_outputs_zero(input string where);
      check_eq({where, "_reqack"}, core_reqack, 0);
      check_eq({where, "_respcyc"}, core_respcyc, 0);
      check_eq({where, "_resp"}, core_resp, 0);
      check_eq({where, "_resptag"}, core_resptag, 0);
      check_eq({where, "_mem_reqcyc"}, mem_reqcyc, 0);
      check_eq({where, "_mem_req"}, mem_req, 0);
      check_eq({where, "_mem_reqtag"}, mem_reqtag, 0);
      check_eq({where, "_respack"}, mem_respack, mem_respcyc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_outputs_zero("reset");
      check_counters_reset();
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic check_counters_reset();
      check_eq("reset_hit_count", hit_count, 0);
      check_eq("reset_miss_count", miss_count, 0);
   endtask

   task automatic idle_stray_beat();
      @(negedge clk);
      mem_respcyc = 1'b1;
      mem_resptag = 13'($urandom);
      mem_resp    = {$urandom, $urandom};
      #1;
      check_eq("idle_stray_ack", mem_respack, 1);
      @(negedge clk);
      mem_respcyc = 1'b0;
      check_eq("idle_stray_norespcyc", core_respcyc, 0);
   endtask

   task automatic do_fetch(input logic [63:0] addr, input logic [12:0] tag, input int count_data,
                           input int bp, input int stray, output int was_miss);
      int s;
      int hit_way;
      int way;
      int lat;
      logic [50:0]  at;
      logic [511:0] blk;
      logic [63:0]  word;
      s = int'(addr[12:6]);
      at = addr[63:13];
      hit_way = -1;
      for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == at) hit_way = w;
      blk = (hit_way >= 0) ? m_data[s][hit_way] : '0;
      was_miss = 0;

      @(negedge clk);
      core_req = addr;
      core_reqtag = tag;
      core_reqcyc = 1'b1;
      @(negedge clk);
      check_eq("reqack", core_reqack, 1);
      core_reqcyc = 1'b0;
      lat = 1;
      while (!core_respcyc && !mem_reqcyc && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (mem_reqcyc) begin
         was_miss = 1;
         check_eq("mem_req", mem_req, {addr[63:6], 6'd0});
         check_eq("mem_reqtag", mem_reqtag, tag);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         check_eq("mem_reqcyc_held", mem_reqcyc, 1);
         mem_reqack = 1'b1;
         @(negedge clk);
         mem_reqack = 1'b0;
         check_eq("mem_reqcyc_drop", mem_reqcyc, 0);
         for (int k = 0; k < 8; k++) begin
            if (stray != 0 && k == 2) begin
               mem_respcyc = 1'b1;
               mem_resptag = tag ^ 13'h1;
               mem_resp    = {$urandom, $urandom};
               #1;
               check_eq("stray_tag_ack", mem_respack, 1);
               @(negedge clk);
               mem_respcyc = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            word = (count_data != 0) ? 64'(k) : {$urandom, $urandom};
            blk[k*64 +: 64] = word;
            mem_respcyc = 1'b1;
            mem_resptag = tag;
            mem_resp    = word;
            #1;
            if (k == 0) check_eq("beat_ack", mem_respack, 1);
            @(negedge clk);
            mem_respcyc = 1'b0;
         end
         lat = 0;
         while (!core_respcyc && lat < 20) begin
            @(negedge clk);
            lat++;
         end
      end
      if (!core_respcyc) begin
         check_eq("resp_timeout", core_respcyc, 1);
         return;
      end
      if (!was_miss) check_eq("hit_latency", lat, 2 + HIT_LAT);
      check_eq("hit_or_miss", was_miss, (hit_way < 0) ? 1 : 0);

      if (hit_way < 0) begin
         way = model_victim(s);
         m_valid[s][way] = 1'b1;
         m_tag[s][way]   = at;
         m_data[s][way]  = blk;
         m_misses++;
      end else begin
         way = hit_way;
         m_hits++;
      end
      model_touch(s, way);

      check_eq("resp_data", core_resp, blk);
      check_eq("resp_tag", core_resptag, tag);
      for (int i = 0; i < bp; i++) begin
         core_req = {$urandom, $urandom};
         core_reqcyc = 1'b1;
         @(negedge clk);
         check_eq("bp_no_reqack", core_reqack, 0);
         check_eq("bp_respcyc", core_respcyc, 1);
         check_eq("bp_resp", core_resp, blk);
         check_eq("bp_resptag", core_resptag, tag);
      end
      core_reqcyc = 1'b0;
      core_respack = 1'b1;
      @(negedge clk);
      core_respack = 1'b0;
      check_eq("respcyc_fall", core_respcyc, 0);
      check_counters();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      int miss;
      int s_sel;
      logic [63:0] a;
      reset = 1'b0;
      core_req = '0;
      core_reqtag = '0;
      core_reqcyc = 1'b0;
      core_respack = 1'b0;
      mem_reqack = 1'b0;
      mem_resp = '0;
      mem_resptag = '0;
      mem_respcyc = 1'b0;
      model_clear();

      do_reset();

      do_fetch(64'h1000, 13'd5, 1, 0, 0, miss);
      check_eq("cold_miss", miss, 1);
      do_fetch(64'h1008, 13'd6, 0, 0, 0, miss);
      check_eq("hit_after_fill", miss, 0);
      do_fetch(64'h1010, 13'd7, 0, 10, 0, miss);

      idle_stray_beat();
      do_fetch(64'h3040, 13'd9, 0, 0, 1, miss);
      idle_stray_beat();
      do_fetch(64'h3048, 13'd10, 0, 0, 0, miss);
      check_eq("stray_block_hit", miss, 0);

      do_reset();
      for (int n = 0; n < 5; n++) begin
         do_fetch(64'h1000 + 64'(n) * 64'h2000, 13'(n), 0, 0, 0, miss);
         check_eq("repl_fill_miss", miss, 1);
      end
      do_fetch(64'h1000, 13'd20, 0, 0, 0, miss);
      check_eq("repl_evicted_way0", miss, 1);

      // Abort a fill part-way through with reset.
      do_reset();
      @(negedge clk);
      core_req = 64'h1000;
      core_reqtag = 13'd5;
      core_reqcyc = 1'b1;
      @(negedge clk);
      core_reqcyc = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rmf_mem_reqcyc", mem_reqcyc, 1);
      mem_reqack = 1'b1;
      @(negedge clk);
      mem_reqack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mem_respcyc = 1'b1;
         mem_resptag = 13'd5;
         mem_resp = 64'(k);
         @(negedge clk);
      end
      mem_respcyc = 1'b0;
      reset = 1'b1;
      #1;
      check_outputs_zero("midfill");
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      for (int k = 3; k < 8; k++) begin
         mem_respcyc = 1'b1;
         mem_resptag = 13'd5;
         mem_resp = 64'(k);
         #1;
         check_eq("late_beat_ack", mem_respack, 1);
         @(negedge clk);
      end
      mem_respcyc = 1'b0;
      check_eq("late_beat_norespcyc", core_respcyc, 0);
      check_eq("late_beat_nomemreq", mem_reqcyc, 0);
      do_fetch(64'h1000, 13'd5, 0, 0, 0, miss);
      check_eq("after_reset_miss", miss, 1);

      for (int i = 0; i < 80; i++) begin
         s_sel = int'($urandom_range(0, 2));
         a = 64'($urandom_range(0, 5)) * 64'h2000
           + ((s_sel == 0) ? 64'h0 : (s_sel == 1) ? 64'h40 : 64'h1000)
           + 64'($urandom_range(0, 7)) * 64'd8;
         if ($urandom_range(0, 5) == 0) idle_stray_beat();
         do_fetch(a, 13'($urandom), 0, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0, miss);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
